// File: rtl/ofm_pkg.sv
// ofm_pkg: shared state type, default sizes and width helper
// for the output-feature-map stream buffer.
package ofm_pkg;

  localparam int OFM_DATA_W = 32;
  localparam int OFM_DEPTH  = 256;
  localparam int OFM_NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } ofm_state_e;

  // A single bank still needs a 1-bit channel field.
  function automatic int ofm_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_bank.sv
// ofm_bank: one DEPTH x DATA_W channel bank, one write port,
// synchronous read with 1-cycle latency.
// Ports: clk_i; we_i/waddr_i/wdata_i write; re_i/raddr_i read;
//        rdata_o holds the last read word until the next re_i.
module ofm_bank
  import ofm_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W,
  parameter int DEPTH  = OFM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately unreset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofm_stream_buffer.sv
// ofm_stream_buffer: NUM_CH banked OFM store that drains the
// whole map over valid/ready in channel-major order on done.
// Ports: clk, rst (async, active-low);
//   wr/wr_ch/wr_addr/wr_data  result writes (IDLE only);
//   done                      start-drain request (level);
//   out_valid/out_ready/out_data/out_ch/out_addr/out_last stream;
//   busy (state != IDLE), drained (1-cycle pulse), wr_err (sticky).
// Option: OFM_CLEAR_ON_DRAIN_EN zeroes each word after it is read.
module ofm_stream_buffer
  import ofm_pkg::*;
#(
  parameter int DATA_W = OFM_DATA_W,
  parameter int DEPTH  = OFM_DEPTH,
  parameter int NUM_CH = OFM_NUM_CH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = ofm_ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              drained,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   CH_MAX   = CH_W'(NUM_CH - 1);

  ofm_state_e state_q, state_d;

  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_end_q, rd_end_d;

  logic [CH_W-1:0]   tag_ch_q, tag_ch_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic              tag_last_q, tag_last_d;
  logic              pend_q, pend_d;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [CH_W-1:0]   och_q, och_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              olast_q, olast_d;

  logic              wr_err_q, wr_err_d;

  logic              rd_en;
  logic              load;
  logic              accept;
  logic              wr_bad_ch;
  logic              wr_ok;
  logic              wr_blk;
  logic              clr;
  logic [DATA_W-1:0] rdata [NUM_CH];
  logic [DATA_W-1:0] rd_mux;

  assign accept = ov_q && out_ready;

  // Issue only when the output register is free next edge, so
  // a bank word is never waiting behind a stalled output word.
  assign rd_en = (state_q == ST_DRAIN) && !rd_end_q
              && (!ov_q || out_ready);

  // Bank output holds while pending, so load can wait a stall.
  assign load = pend_q && (!ov_q || out_ready);

  assign wr_bad_ch = 32'(wr_ch) >= NUM_CH;
  assign wr_ok     = wr && (state_q == ST_IDLE) && !wr_bad_ch;
  assign wr_blk    = wr && !wr_ok;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tag_ch_q == CH_W'(i)) begin
        rd_mux = rdata[i];
      end
    end
  end

  // State and read pointer.
  always_comb begin
    state_d   = state_q;
    rd_ch_d   = rd_ch_q;
    rd_addr_d = rd_addr_q;
    rd_end_d  = rd_end_q;
    unique case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d   = ST_DRAIN;
          rd_ch_d   = '0;
          rd_addr_d = '0;
          rd_end_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (rd_en) begin
          if (rd_addr_q == ADDR_MAX) begin
            rd_addr_d = '0;
            if (rd_ch_q == CH_MAX) begin
              rd_end_d = 1'b1;
            end else begin
              rd_ch_d = rd_ch_q + 1'b1;
            end
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        if (accept && olast_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read tag, pending flag and output register.
  always_comb begin
    tag_ch_d   = tag_ch_q;
    tag_addr_d = tag_addr_q;
    tag_last_d = tag_last_q;
    pend_d     = pend_q;
    ov_d       = ov_q;
    od_d       = od_q;
    och_d      = och_q;
    oaddr_d    = oaddr_q;
    olast_d    = olast_q;
    wr_err_d   = wr_err_q | wr_blk;

    if (load) begin
      ov_d    = 1'b1;
      od_d    = rd_mux;
      och_d   = tag_ch_q;
      oaddr_d = tag_addr_q;
      olast_d = tag_last_q;
    end else if (accept) begin
      ov_d = 1'b0;
    end

    if (rd_en) begin
      pend_d     = 1'b1;
      tag_ch_d   = rd_ch_q;
      tag_addr_d = rd_addr_q;
      tag_last_d = (rd_ch_q == CH_MAX)
                && (rd_addr_q == ADDR_MAX);
    end else if (load) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rd_ch_q    <= '0;
      rd_addr_q  <= '0;
      rd_end_q   <= 1'b0;
      tag_ch_q   <= '0;
      tag_addr_q <= '0;
      tag_last_q <= 1'b0;
      pend_q     <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      och_q      <= '0;
      oaddr_q    <= '0;
      olast_q    <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ch_q    <= rd_ch_d;
      rd_addr_q  <= rd_addr_d;
      rd_end_q   <= rd_end_d;
      tag_ch_q   <= tag_ch_d;
      tag_addr_q <= tag_addr_d;
      tag_last_q <= tag_last_d;
      pend_q     <= pend_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      och_q      <= och_d;
      oaddr_q    <= oaddr_d;
      olast_q    <= olast_d;
      wr_err_q   <= wr_err_d;
    end
  end

`ifdef OFM_CLEAR_ON_DRAIN_EN
  // The tag still names the word read last cycle; zero it
  // through the write port, idle since writes are blocked.
  logic clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_q <= 1'b0;
    end else begin
      clr_q <= rd_en;
    end
  end

  assign clr = clr_q;
`else
  assign clr = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_bank
    logic              sel_wr;
    logic              sel_clr;
    logic              sel_rd;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign sel_wr  = wr_ok && (wr_ch == CH_W'(i));
    assign sel_clr = clr && (tag_ch_q == CH_W'(i));
    assign sel_rd  = rd_en && (rd_ch_q == CH_W'(i));
    assign we      = sel_wr || sel_clr;
    assign waddr   = sel_clr ? tag_addr_q : wr_addr;
    assign wdata   = sel_clr ? '0 : wr_data;

    ofm_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (sel_rd),
      .raddr_i (rd_addr_q),
      .rdata_o (rdata[i])
    );
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_ch    = och_q;
  assign out_addr  = oaddr_q;
  assign out_last  = olast_q;
  assign busy      = (state_q != ST_IDLE);
  assign drained   = (state_q == ST_FLUSH);
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_ofm_stream_buffer.sv
// tb_ofm_stream_buffer: self-checking bench for the OFM stream
// buffer, 3 channels x 64 words so channel 3 is out of range.
module tb_ofm_stream_buffer;

  localparam int DW = 32;
  localparam int DP = 64;
  localparam int NC = 3;
  localparam int AW = 6;
  localparam int CW = 2;
  localparam int NW = NC * DP;

`ifdef OFM_CLEAR_ON_DRAIN_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          drained;
  logic          wr_err;

  always #5 clk = ~clk;

  ofm_stream_buffer #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .NUM_CH (NC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .wr_ch     (wr_ch),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .drained   (drained),
    .wr_err    (wr_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] model [NC][DP];

  typedef struct {
    int          ch;
    int          addr;
    logic [31:0] data;
    logic        err;
  } wvec_t;

  wvec_t wt [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int c, input int a,
                         input logic [DW-1:0] d);
    wr      = 1'b1;
    wr_ch   = CW'(c);
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr = 1'b0;
    if (c < NC) model[c][a] = d;
  endtask

  task automatic fill();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < DP; a++)
        wr_word(c, a, {8'(c), 24'(a)});
  endtask

  // Stream order is channel-major, address-ascending.
  function automatic logic [63:0] exp_word(input int i);
    int c;
    int a;
    c = i / DP;
    a = i % DP;
    return {23'd0, (i == NW - 1), 2'(c), 6'(a), model[c][a]};
  endfunction

  task automatic drain(input bit rnd, input int stall_at,
                       input int inj_at, input int abort_at,
                       input bit cowr, input logic [DW-1:0] cowr_d);
    int k, idx, fk, dk, ak, dcnt, stall, budget;
    bit sd, inj_done, rdy;
    k = 0; idx = 0; fk = 0; dk = 0; ak = -1;
    dcnt = 0; stall = 0; sd = 0; inj_done = 0;
    budget = NW * 8 + 64;
    done = 1'b1;
    if (cowr) begin
      wr = 1'b1; wr_ch = 2'd2; wr_addr = 6'd10; wr_data = cowr_d;
      model[2][10] = cowr_d;
    end
    while (k < budget && !(dk != 0 && k > dk + 1)) begin
      step();
      k++;
      done = 1'b0;
      wr = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (4) begin
          step();
          if (drained) dcnt++;
        end
        chk("abort_drained", 64'(dcnt), 64'(0));
        rst = 1'b1;
        return;
      end
      if (drained) begin
        dcnt++;
        dk = k;
      end
      if (out_valid && fk == 0) fk = k;
      if (inj_at >= 0 && idx == inj_at && !inj_done) begin
        wr = 1'b1; wr_ch = 2'd1; wr_addr = 6'd5;
        wr_data = 32'hDEADBEEF;
        inj_done = 1'b1;
      end
      if (stall_at >= 0 && idx == stall_at && !sd) begin
        stall = 10;
        sd = 1'b1;
      end
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      out_ready = rdy;
      if (out_valid) begin
        if (idx < NW) begin
          chk($sformatf("word%0d", idx),
              {23'd0, out_last, out_ch, out_addr, out_data},
              exp_word(idx));
          if (rdy) begin
            if (idx == NW - 1) ak = k;
            idx++;
          end
        end else begin
          chk("extra_valid", 64'(out_valid), 64'(0));
        end
      end
    end
    out_ready = 1'b0;
    chk("first_valid_lat", 64'(fk), 64'(3));
    chk("word_count", 64'(idx), 64'(NW));
    chk("drained_cnt", 64'(dcnt), 64'(1));
    chk("drained_time", 64'(dk), 64'(ak + 1));
    chk("busy_end", 64'(busy), 64'(0));
    if (CLR)
      for (int c = 0; c < NC; c++)
        for (int a = 0; a < DP; a++)
          model[c][a] = '0;
  endtask

  initial begin
    int rc;
    int ra;

    wt[0] = '{0, 3, 32'hA0A0_0003, 1'b0};
    wt[1] = '{2, 63, 32'hB2B2_003F, 1'b0};
    wt[2] = '{1, 0, 32'hC1C1_0000, 1'b0};
    wt[3] = '{3, 7, 32'hBAD0_0007, 1'b1};
    wt[4] = '{0, 63, 32'hD0D0_003F, 1'b1};
    wt[5] = '{3, 0, 32'hBAD0_0000, 1'b1};

    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ch", 64'(out_ch), 64'(0));
    chk("rst_addr", 64'(out_addr), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_drained", 64'(drained), 64'(0));
    chk("rst_wr_err", 64'(wr_err), 64'(0));
    rst = 1'b1;
    step();

    fill();
    chk("wr_err_idle", 64'(wr_err), 64'(0));
    drain(1'b0, -1, -1, -1, 1'b0, '0);

    drain(1'b1, 50, 40, -1, 1'b0, '0);
    chk("wr_err_blocked", 64'(wr_err), 64'(1));

    drain(1'b0, -1, -1, -1, 1'b1, 32'h1234_5678);

    drain(1'b0, -1, -1, 100, 1'b0, '0);
    chk("wr_err_after_rst", 64'(wr_err), 64'(0));
    step();

    fill();
    for (int i = 0; i < 6; i++) begin
      wr_word(wt[i].ch, wt[i].addr, wt[i].data);
      chk($sformatf("tbl_err%0d", i), 64'(wr_err), 64'(wt[i].err));
    end
    drain(1'b0, -1, -1, -1, 1'b0, '0);

    for (int i = 0; i < 40; i++) begin
      rc = int'($urandom_range(0, NC));
      ra = int'($urandom_range(0, DP - 1));
      wr_word(rc, ra, $urandom());
    end
    chk("wr_err_sticky", 64'(wr_err), 64'(1));
    drain(1'b1, int'($urandom_range(0, NW - 1)), -1, -1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ofm_stream_buffer.md
Name: ofm_stream_buffer

Overview:
- Synthesizable, parametrised output-feature-map buffer.
- Holds NUM_CH independent channel banks of DEPTH words each, DATA_W bits wide.
- Accepts result writes from the compute datapath.
- When `done` is asserted, drains the whole map over a valid/ready stream in channel-major, address-ascending order.
- Replaces the file-dump style OFM store: the next stage (DMA or host bridge) receives data in hardware.

Parameters:
- DATA_W, 32, word width.
- DEPTH, 256, words per channel; any value ≥ 2.
- NUM_CH, 4, channel banks; any value ≥ 1.
- ADDR_W, $clog2(DEPTH), address width (derived).
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel index width (derived).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr  in  1  write strobe.
- wr_ch  in  CH_W  write channel.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- done  in  1  start-drain request (level sampled).
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  stream word.
- out_ch  out  CH_W  channel of the current word.
- out_addr  out  ADDR_W  address of the current word.
- out_last  out  1  final word of the map (ch NUM_CH-1, addr DEPTH-1).
- busy  out  1  high while state ≠ IDLE.
- drained  out  1  one-cycle pulse after the last word is accepted.
- wr_err  out  1  sticky; set by a blocked write, cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - out_valid, out_data, out_ch, out_addr, out_last, busy, drained and wr_err all go to 0.
  - Read pointers go to 0.
  - Memory contents are not reset and are undefined after power-up.
- States: IDLE, DRAIN, FLUSH.
- IDLE:
  - wr=1 writes wr_data to bank[wr_ch][wr_addr] at the clock edge.
  - wr_ch ≥ NUM_CH: write dropped, wr_err set.
  - done=1 sampled: go to DRAIN and set the read pointer to (0,0). A write in the same cycle still commits.
- DRAIN:
  - Banks are synchronous-read with 1-cycle latency; one output register follows.
  - A read is issued when the output register will be free: (!out_valid || out_ready) and the pointer has not passed the end.
  - Read data and its tag (ch, addr, last) load the output register on the next edge, with out_valid=1.
  - First out_valid appears 2 cycles after done is sampled.
  - Sustained throughput is 1 word/cycle while out_ready=1.
  - out_valid=1 && out_ready=0: out_data/out_ch/out_addr/out_last hold stable and no read is issued.
  - Pointer increments addr first; at addr DEPTH-1 it wraps to 0 and ch increments.
  - After (NUM_CH-1, DEPTH-1) is issued, no further reads are issued.
  - Any wr=1 in DRAIN or FLUSH is ignored and sets wr_err.
  - done re-asserted in DRAIN or FLUSH is ignored.
  - When the out_last word is accepted (out_valid && out_ready && out_last): out_valid drops next cycle and the state goes to FLUSH.
- FLUSH:
  - Asserts drained for exactly one cycle, then returns to IDLE.
  - If done is still high on return to IDLE, a new drain starts. The producer must deassert done before that cycle if a repeat drain is not wanted.
- Total words per drain: NUM_CH·DEPTH, exactly once each, no gaps or repeats.
- Reset during DRAIN aborts immediately. No drained pulse is produced and the partial stream is discarded by the consumer.

Optional Feature:
- Macro: OFM_CLEAR_ON_DRAIN_EN.
- Defined:
  - Each word is written to zero in the cycle after it is read in DRAIN, using the bank's write port, which is free because external writes are blocked.
  - After a complete drain every bank location reads 0, so the buffer is ready for the next accumulation pass without a separate clear.
  - An aborted drain clears only the words already read.
- Undefined: contents are preserved across drains, so a second drain returns identical data.

Decomposition:
- Package ofm_pkg holds:
  - the state enum (IDLE, DRAIN, FLUSH);
  - default DATA_W, DEPTH and NUM_CH constants;
  - a helper function for CH_W.
- Sub-module ofm_bank: one DEPTH×DATA_W bank with 1 write port and synchronous read, instantiated NUM_CH times in a generate loop.
- Top level contains the FSM, read pointer, output register and write steering.

Test Plan:
- Reset/basic drain:
  - Stimulus: write bank[c][a] = {c[7:0], 24'(a)} for all locations, pulse done, hold out_ready=1.
  - Response: 1024 words in order (0,0)…(3,255) with matching data; out_last only on (3,255); drained pulses once; busy back to 0.
- Backpressure:
  - Stimulus: toggle out_ready in a random pattern, including a 10-cycle stall mid-stream.
  - Response: no word lost or duplicated; out_data stable while stalled.
- Write blocking:
  - Stimulus: wr=1 to (1,5) with 0xDEADBEEF during DRAIN.
  - Response: word (1,5) keeps its old value; wr_err=1 until reset.
- Edge cases:
  - Stimulus: wr_ch=NUM_CH in IDLE.
  - Response: write dropped, wr_err=1.
  - Stimulus: done asserted in the same cycle as a write.
  - Response: that write appears in the drained stream.
- Reset mid-drain:
  - Stimulus: assert rst low after 100 accepted words.
  - Response: out_valid=0 immediately, no drained pulse; a new done after reset drains from (0,0).
- OFM_CLEAR_ON_DRAIN_EN:
  - Stimulus: with the macro defined, run two back-to-back drains with no writes between.
  - Response: second drain is all zeros.
  - Stimulus: same sequence without the macro.
  - Response: second drain is identical to the first.
